// File: rtl/jk_bank_pkg.sv
// jk_bank_pkg
// Shared definitions for the JK bank arbiter slice:
//   - parameter defaults for requester count, bank width and lock burst length
//   - opcode encoding of the per-requester JK command (bit 1 = J, bit 0 = K)
//   - jk_next(): next-state function of a single JK bit
package jk_bank_pkg;

  localparam int NREQ_DEF     = 4;
  localparam int WIDTH_DEF    = 8;
  localparam int LOCK_MAX_DEF = 4;

  // The opcode is literally {J, K}, so the cell can take op[1] as J and op[0] as K.
  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_CLR  = 2'b01,
    JK_SET  = 2'b10,
    JK_TGL  = 2'b11
  } jk_op_e;

  // Classic JK characteristic equation: Q+ = J & ~Q | ~K & Q.
  function automatic logic jk_next(input logic q, input logic j, input logic k);
    return (j & ~q) | (~k & q);
  endfunction

endpackage

// File: rtl/jk_bank_arbiter_if.sv
// jk_bank_arbiter_if
// Bundles the requester-side command bus and the bank/arbiter outputs.
//   master modport : requester side (drives req/lock/op/mask, observes the rest)
//   slave modport  : jk_bank_arbiter side
// Signals:
//   req     [NREQ]        per-requester command valid
//   lock    [NREQ]        burst-lock flag, meaningful only while req is high
//   op      [2*NREQ]      opcode of requester i in op[2i+1:2i]
//   mask    [WIDTH*NREQ]  bit mask of requester i in mask[WIDTH*i +: WIDTH]
//   gnt     [NREQ]        one-hot grant (combinational)
//   q       [WIDTH]       registered JK bank state
//   upd                   one-cycle pulse after each applied command
//   last_id [ID_W]        index of the most recently granted requester
//   dbg_ptr, dbg_lock_cnt observation of the arbiter's internal state
//
// Handshake: req[i] is requester i's valid, gnt[i] is its ready. A command
// transfers on a rising clk edge where req[i] and gnt[i] are both high; until
// then the requester keeps req[i], lock[i], op and mask slices stable. A
// command presented during reset is not consumed and must stay presented.
//
// NREQ/WIDTH/LOCK_MAX must match the values given to jk_bank_arbiter.
interface jk_bank_arbiter_if
  import jk_bank_pkg::*;
#(
  parameter int NREQ     = NREQ_DEF,
  parameter int WIDTH    = WIDTH_DEF,
  parameter int LOCK_MAX = LOCK_MAX_DEF
);

  localparam int ID_W  = $clog2(NREQ);
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       lock;
  logic [2*NREQ-1:0]     op;
  logic [WIDTH*NREQ-1:0] mask;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      q;
  logic                  upd;
  logic [ID_W-1:0]       last_id;
  logic [ID_W-1:0]       dbg_ptr;
  logic [CNT_W-1:0]      dbg_lock_cnt;

  modport master (
    output req, lock, op, mask,
    input  gnt, q, upd, last_id, dbg_ptr, dbg_lock_cnt
  );

  modport slave (
    input  req, lock, op, mask,
    output gnt, q, upd, last_id, dbg_ptr, dbg_lock_cnt
  );

endinterface

// File: rtl/jk_cell.sv
// jk_cell
// One bit of the JK bank: a JK flip-flop with clock enable.
// Ports:
//   clk    clock, rising edge
//   reset  synchronous, active-high; clears q and wins over en
//   en     apply the J/K inputs on this edge
//   j, k   JK inputs
//   q      registered bit
module jk_cell
  import jk_bank_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 1'b0;
    end else if (en) begin
      q <= jk_next(q, j, k);
    end
  end

endmodule

// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter
// Round-robin arbiter with burst lock in front of a bank of WIDTH JK bits.
// Each cycle at most one requester is granted; its opcode is applied to the
// bank bits selected by its mask on the transfer edge.
// Ports:
//   clk    clock, rising edge
//   reset  synchronous, active-high
//   bus    jk_bank_arbiter_if.slave (req/lock/op/mask in; gnt/q/upd/last_id
//          and debug view of ptr/lock_cnt out)
// Parameters:
//   NREQ      number of requesters (2..8)
//   WIDTH     number of JK bits
//   LOCK_MAX  max consecutive grants to a locked requester
module jk_bank_arbiter
  import jk_bank_pkg::*;
#(
  parameter int NREQ     = NREQ_DEF,
  parameter int WIDTH    = WIDTH_DEF,
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input logic              clk,
  input logic              reset,
  jk_bank_arbiter_if.slave bus
);

  localparam int ID_W  = $clog2(NREQ);
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NREQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

  // Arbiter state
  logic [ID_W-1:0]  ptr;
  logic [CNT_W-1:0] lock_cnt;
  logic             upd_r;
  logic [ID_W-1:0]  last_id_r;

  // Grant decode results
  logic             win_vld;
  logic [ID_W-1:0]  win_id;
  logic [NREQ-1:0]  gnt;
  logic             xfer;

  // Command of the winning requester
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_mask;
  logic             sel_lock;

  // Next arbiter state
  logic [ID_W-1:0]  next_ptr;
  logic [CNT_W-1:0] base_cnt;
  logic [CNT_W-1:0] next_cnt;

  logic [WIDTH-1:0] q_bits;

  // Scan from ptr upward, wrapping modulo NREQ; first requester found wins.
  // The index is built with an explicit wrap so non-power-of-two NREQ works.
  always_comb begin
    int sum;
    logic [ID_W-1:0] idx;
    win_vld = 1'b0;
    win_id  = '0;
    gnt     = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = int'(ptr) + k;
      if (sum >= NREQ) begin
        sum = sum - NREQ;
      end
      idx = ID_W'(sum);
      if (!win_vld && bus.req[idx]) begin
        win_vld = 1'b1;
        win_id  = idx;
      end
    end
    if (win_vld && !reset) begin
      gnt[win_id] = 1'b1;
    end
  end

  // A grant always coincides with req, and reset suppresses both.
  assign xfer = win_vld & ~reset;

  // Select the winner's opcode, mask and lock flag.
  always_comb begin
    sel_op   = 2'b00;
    sel_mask = '0;
    sel_lock = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_id == ID_W'(i)) begin
        sel_op   = bus.op[2*i +: 2];
        sel_mask = bus.mask[WIDTH*i +: WIDTH];
        sel_lock = bus.lock[i];
      end
    end
  end

  // Pointer/lock counter update. A nonzero lock_cnt always belongs to the
  // requester sitting at ptr, so a win by anyone else starts counting from 0.
  // Once the burst has used LOCK_MAX grants the pointer moves on even if the
  // requester still asks for the lock.
  always_comb begin
    next_ptr = ptr;
    next_cnt = lock_cnt;
    base_cnt = (win_id == ptr) ? lock_cnt : '0;
    if (xfer) begin
      if (sel_lock && (base_cnt != CNT_LAST)) begin
        next_ptr = win_id;
        next_cnt = base_cnt + CNT_W'(1);
      end else begin
        next_ptr = (win_id == ID_LAST) ? '0 : win_id + ID_W'(1);
        next_cnt = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      lock_cnt  <= '0;
      upd_r     <= 1'b0;
      last_id_r <= '0;
    end else begin
      ptr      <= next_ptr;
      lock_cnt <= next_cnt;
      upd_r    <= xfer;
      if (xfer) begin
        last_id_r <= win_id;
      end
    end
  end

  // The bank: only masked bits of the winner see an enable.
  for (genvar b = 0; b < WIDTH; b++) begin : g_bank
    jk_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .en    (xfer & sel_mask[b]),
      .j     (sel_op[1]),
      .k     (sel_op[0]),
      .q     (q_bits[b])
    );
  end

  assign bus.gnt          = gnt;
  assign bus.q            = q_bits;
  assign bus.upd          = upd_r;
  assign bus.last_id      = last_id_r;
  assign bus.dbg_ptr      = ptr;
  assign bus.dbg_lock_cnt = lock_cnt;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// tb_jk_bank_arbiter
// Directed scenarios followed by constrained-random traffic. A reference model
// of the round-robin/lock arbiter and the JK bank predicts each transfer; the
// expected {last_id, q} is queued when the command is driven and compared when
// the DUT reports upd.
module tb_jk_bank_arbiter;
  import jk_bank_pkg::*;

  localparam int NREQ     = 4;
  localparam int WIDTH    = 8;
  localparam int LOCK_MAX = 4;
  localparam int ID_W     = 2;
  localparam int EW       = ID_W + WIDTH;

  logic clk = 1'b0;
  logic reset;

  jk_bank_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .LOCK_MAX(LOCK_MAX)) bus ();

  jk_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LOCK_MAX(LOCK_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [WIDTH-1:0] m_q;
  int               m_ptr;
  int               m_cnt;
  logic [EW-1:0]    exp_q[$];
  bit               pend[NREQ];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input bit r, input bit lk,
                         input logic [1:0] o, input logic [WIDTH-1:0] m);
    bus.req[i]              = r;
    bus.lock[i]             = lk;
    bus.op[2*i +: 2]        = o;
    bus.mask[i*WIDTH +: WIDTH] = m;
  endtask

  task automatic clear_all();
    bus.req  = '0;
    bus.lock = '0;
    bus.op   = '0;
    bus.mask = '0;
  endtask

  // One clock cycle: predict grant and effect of the currently driven inputs,
  // then check the outputs after the edge. Returns the predicted winner or -1.
  task automatic step(output int w);
    logic [NREQ-1:0]  eg;
    logic [1:0]       o;
    logic [WIDTH-1:0] mk;
    logic [WIDTH-1:0] nv;
    logic [EW-1:0]    e;
    int               base;
    bit               exp_upd;
    bit               was_reset;
    #1;
    w = -1;
    if (!reset) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NREQ;
        if (w < 0 && bus.req[idx]) w = idx;
      end
    end
    eg = '0;
    if (w >= 0) eg = NREQ'(1) << w;
    check("gnt", 32'(bus.gnt), 32'(eg));

    exp_upd   = 1'b0;
    was_reset = reset;
    if (reset) begin
      m_q   = '0;
      m_ptr = 0;
      m_cnt = 0;
    end else if (w >= 0) begin
      o  = bus.op[2*w +: 2];
      mk = bus.mask[w*WIDTH +: WIDTH];
      case (o)
        2'b01:   nv = '0;
        2'b10:   nv = '1;
        2'b11:   nv = ~m_q;
        default: nv = m_q;
      endcase
      m_q  = (m_q & ~mk) | (nv & mk);
      base = (w == m_ptr) ? m_cnt : 0;
      if (bus.lock[w] && base < LOCK_MAX - 1) begin
        m_ptr = w;
        m_cnt = base + 1;
      end else begin
        m_ptr = (w + 1) % NREQ;
        m_cnt = 0;
      end
      exp_q.push_back({ID_W'(w), m_q});
      exp_upd = 1'b1;
    end

    @(posedge clk);
    #1;
    check("upd", 32'(bus.upd), 32'(exp_upd));
    check("q", 32'(bus.q), 32'(m_q));
    check("ptr", 32'(bus.dbg_ptr), 32'(m_ptr));
    check("lock_cnt", 32'(bus.dbg_lock_cnt), 32'(m_cnt));
    if (was_reset) check("last_id_rst", 32'(bus.last_id), 32'd0);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_id_q", 32'({bus.last_id, bus.q}), 32'(e));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    int exp_ids[5];
    int exp_cnts[5];
    m_q   = '0;
    m_ptr = 0;
    m_cnt = 0;
    clear_all();
    reset = 1'b1;
    step(w);
    step(w);
    reset = 1'b0;

    // Single set on requester 0
    set_req(0, 1'b1, 1'b0, JK_SET, 8'h0F);
    step(w);
    check("r033_q", 32'(bus.q), 32'h0F);
    check("r033_upd", 32'(bus.upd), 32'd1);
    check("r033_id", 32'(bus.last_id), 32'd0);
    clear_all();

    // Zero-mask transfer from requester 3 brings ptr back to 0, q unchanged
    set_req(3, 1'b1, 1'b0, JK_SET, 8'h00);
    step(w);
    check("zmask_q", 32'(bus.q), 32'h0F);
    check("zmask_upd", 32'(bus.upd), 32'd1);
    clear_all();

    // Two requesters, each drops after its own transfer
    set_req(0, 1'b1, 1'b0, JK_TGL, 8'hFF);
    set_req(1, 1'b1, 1'b0, JK_CLR, 8'hF0);
    step(w);
    check("r034_q0", 32'(bus.q), 32'hF0);
    check("r034_id0", 32'(bus.last_id), 32'd0);
    set_req(0, 1'b0, 1'b0, JK_HOLD, 8'h00);
    step(w);
    check("r034_q1", 32'(bus.q), 32'h00);
    check("r034_id1", 32'(bus.last_id), 32'd1);
    clear_all();

    // Reposition ptr to 0, then full round robin
    set_req(3, 1'b1, 1'b0, JK_HOLD, 8'hFF);
    step(w);
    clear_all();
    exp_ids = '{0, 1, 2, 3, 0};
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, JK_TGL, WIDTH'(8'h11 << i));
    for (int c = 0; c < 5; c++) begin
      step(w);
      check("r035_order", 32'(bus.last_id), 32'(exp_ids[c]));
    end
    clear_all();

    // Locked burst capped at LOCK_MAX grants
    exp_ids  = '{1, 1, 1, 1, 2};
    exp_cnts = '{1, 2, 3, 0, 0};
    set_req(1, 1'b1, 1'b1, JK_TGL, 8'h01);
    set_req(2, 1'b1, 1'b0, JK_SET, 8'h80);
    for (int c = 0; c < 5; c++) begin
      step(w);
      check("r036_order", 32'(bus.last_id), 32'(exp_ids[c]));
      check("r036_cnt", 32'(bus.dbg_lock_cnt), 32'(exp_cnts[c]));
    end
    clear_all();

    // Reset on the same edge as a set transfer; command then re-presented
    set_req(0, 1'b1, 1'b0, JK_SET, 8'hFF);
    reset = 1'b1;
    step(w);
    check("r037_q", 32'(bus.q), 32'h00);
    check("r037_upd", 32'(bus.upd), 32'd0);
    check("r037_ptr", 32'(bus.dbg_ptr), 32'd0);
    reset = 1'b0;
    step(w);
    check("r037_redo_q", 32'(bus.q), 32'hFF);
    clear_all();

    // q = 0x5A, then a hold with full mask from requester 2
    set_req(0, 1'b1, 1'b0, JK_CLR, 8'hA5);
    step(w);
    clear_all();
    set_req(2, 1'b1, 1'b0, JK_HOLD, 8'hFF);
    step(w);
    check("r038_q", 32'(bus.q), 32'h5A);
    check("r038_upd", 32'(bus.upd), 32'd1);
    check("r038_id", 32'(bus.last_id), 32'd2);
    clear_all();

    // Reset mid-burst ends the lock; requester 0 first afterwards
    set_req(2, 1'b1, 1'b1, JK_TGL, 8'h0F);
    step(w);
    step(w);
    reset = 1'b1;
    step(w);
    reset = 1'b0;
    clear_all();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, JK_HOLD, 8'h00);
    step(w);
    check("r029_id", 32'(bus.last_id), 32'd0);
    clear_all();

    // Locker drops req; another requester's transfer clears lock_cnt
    set_req(1, 1'b1, 1'b1, JK_SET, 8'h03);
    step(w);
    step(w);
    clear_all();
    set_req(3, 1'b1, 1'b0, JK_CLR, 8'h01);
    step(w);
    check("r024_cnt", 32'(bus.dbg_lock_cnt), 32'd0);
    check("r024_id", 32'(bus.last_id), 32'd3);
    clear_all();

    // Idle cycle
    step(w);
    check("idle_upd", 32'(bus.upd), 32'd0);

    // Random traffic with hold-until-transfer and occasional reset
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          set_req(i, 1'b1, ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
                  WIDTH'($urandom_range(0, 255)));
          pend[i] = 1'b1;
        end
      end
      reset = ($urandom_range(0, 49) == 0);
      step(w);
      if (w >= 0) begin
        pend[w] = 1'b0;
        set_req(w, 1'b0, 1'b0, JK_HOLD, 8'h00);
      end
    end
    reset = 1'b0;
    clear_all();
    step(w);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/jk_bank_arbiter.md
JK_BANK_ARBITER -- requirements
Module: jk_bank_arbiter

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters (2..8).
REQ-002 Parameter WIDTH, default 8, SHALL set the number of JK bits in the bank.
REQ-003 Parameter LOCK_MAX, default 4, SHALL set the maximum consecutive grants to one locked requester.
REQ-004 clk  in  1  SHALL be the clock; all state updates on the rising edge.
REQ-005 reset  in  1  SHALL be a synchronous, active-high reset.
REQ-006 req  in  NREQ  SHALL carry per-requester command requests.
REQ-007 lock  in  NREQ  SHALL carry per-requester burst-lock flags; each is valid only with its req bit.
REQ-008 op  in  2*NREQ  SHALL carry per-requester opcodes; requester i uses bits [2i+1:2i].
REQ-009 mask  in  WIDTH*NREQ  SHALL carry per-requester bit masks; requester i uses slice i.
REQ-010 gnt  out  NREQ  SHALL be the one-hot grant, combinational from req, lock and registered arbiter state.
REQ-011 q  out  WIDTH  SHALL be the registered JK bank state.
REQ-012 upd  out  1  SHALL pulse high one cycle after every applied command.
REQ-013 last_id  out  clog2(NREQ)  SHALL hold the index of the most recently granted requester.

Function
REQ-014 Opcodes SHALL be 00 hold (j0 k0), 01 clear (j0 k1), 10 set (j1 k0), 11 toggle (j1 k1).
REQ-015 At most one gnt bit SHALL be high per cycle; gnt SHALL be all-zero when req is zero or reset is high.
REQ-016 Transfer SHALL occur on a rising edge with req[i] and gnt[i] both high; requesters hold req/op/mask/lock stable until transfer.
REQ-017 On transfer, each bit b with mask[i][b]=1 SHALL update per the JK rule for op[i]; bits with mask 0 SHALL hold.
REQ-018 q SHALL show the new value in the cycle after the transfer edge (latency 1); upd and last_id SHALL update on the same edge as q.
REQ-019 A transfer with op 00 or an all-zero mask SHALL still consume the grant and pulse upd; q SHALL be unchanged.
REQ-020 Arbitration SHALL be round-robin from a registered pointer ptr; the first requesting index at or after ptr, modulo NREQ, wins.
REQ-021 After an unlocked transfer by requester w, ptr SHALL become (w+1) mod NREQ and lock_cnt SHALL become 0.
REQ-022 After a transfer by w with lock[w]=1, ptr SHALL stay at w and lock_cnt SHALL increment.
REQ-023 When lock_cnt reaches LOCK_MAX-1 and a further locked transfer occurs, ptr SHALL advance to (w+1) mod NREQ and lock_cnt SHALL clear, regardless of lock.
REQ-024 If the locking requester drops req, arbitration SHALL proceed from ptr unchanged and lock_cnt SHALL clear on the next transfer by another requester.
REQ-025 With no transfer, ptr and lock_cnt SHALL hold and upd SHALL be 0.
REQ-026 Pointer wrap SHALL use modulo NREQ arithmetic; lock_cnt SHALL be clog2(LOCK_MAX+1) bits and never exceed LOCK_MAX-1.

Reset
REQ-027 When reset is high at a rising edge: q=0, ptr=0, lock_cnt=0, upd=0, last_id=0.
REQ-028 Reset SHALL take precedence over a transfer on the same edge; that command SHALL be discarded and the requester SHALL re-present it.
REQ-029 Reset asserted mid-burst SHALL end the lock; after reset, requester 0 has highest priority.

Structure
REQ-030 A shared package jk_bank_pkg SHALL hold the opcode constants (JK_HOLD, JK_CLR, JK_SET, JK_TGL) and the parameter defaults.
REQ-031 The bank SHALL be WIDTH instances of sub-module jk_cell (one JK bit with enable and synchronous active-high reset).
REQ-032 Arbitration logic (ptr, lock_cnt, grant decode) SHALL stay in jk_bank_arbiter.

Verification
REQ-033 After reset: req=0001, op0=10, mask0=0x0F -> gnt=0001; next cycle q=0x0F, upd=1, last_id=0.
REQ-034 q=0x0F; req=0011 held, op0=11 mask0=0xFF, op1=01 mask1=0xF0; each requester drops req after its own transfer -> grants 0 then 1; q=0xF0, then 0x00.
REQ-035 req=1111 held, no lock, ptr=0 -> grant order 0,1,2,3,0 on consecutive cycles.
REQ-036 LOCK_MAX=4; req=0110 held, lock[1]=1 -> requester 1 granted 4 consecutive cycles, then requester 2.
REQ-037 Reset on the same edge as a set transfer with mask 0xFF -> q=0x00, upd=0, ptr=0.
REQ-038 req=0100, op2=00, mask2=0xFF with q=0x5A -> gnt=0100, upd=1, q stays 0x5A, last_id=2.
